// File: rtl/day3_line_framer.sv
// Checks the 0xAA frame header from ua_rx and packs each line into a right-justified BCD word.
// line_valid rises 1 cycle after a line's last byte; while it waits on line_ready one byte is skid-buffered and further bytes are dropped.
module day3_line_framer #(
  parameter int MAX_BYTES = 50,
  parameter int TIMEOUT   = 120000
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_par_ok,
  output logic [8*MAX_BYTES-1:0] line_data,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic                   line_last,
  output logic [7:0]             line_bytes,
  output logic [11:0]            n_lines,
  output logic [3:0]             n_digits,
  output logic                   frame_done,
  output logic                   hdr_err,
  output logic                   par_err,
  output logic                   ovr_err,
  output logic                   tmo_err
);
  localparam int          DW       = 8 * MAX_BYTES;
  localparam logic [7:0]  MAX_LEN  = 8'(MAX_BYTES);
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT - 1);

  typedef enum logic [2:0] {SYNC, H1, H2, H3, LOAD, HOLD} state_t;

  state_t      state, state_nxt;
  logic        skid_full;
  logic [7:0]  skid_dat;
  logic [7:0]  len_q;
  logic [7:0]  lines_hi;
  logic [11:0] remaining;
  logic [7:0]  byte_cnt;
  logic [16:0] tmo_cnt;

  logic        in_vld;
  logic [7:0]  in_dat;
  logic        timed;
  logic        tmo_hit;
  logic        handshake;
  logic        line_end;
  logic        hdr_ok;
  logic [11:0] hdr_lines;
  logic [3:0]  hdr_nd;

  // Outside HOLD a buffered byte always goes first; a byte arriving that cycle takes its place.
  always_comb begin
    in_vld = 1'b0;
    in_dat = rx_data;
    if (state != HOLD) begin
      if (skid_full) begin
        in_vld = 1'b1;
        in_dat = skid_dat;
      end else begin
        in_vld = rx_valid;
      end
    end
  end

  always_comb begin
    timed     = state inside {H1, H2, H3, LOAD};
    tmo_hit   = timed && !rx_valid && (tmo_cnt == TMO_LAST);
    handshake = (state == HOLD) && line_ready;
    line_end  = (state == LOAD) && in_vld && ((byte_cnt + 8'd1) == line_bytes);
    hdr_lines = {lines_hi, in_dat[7:4]};
    hdr_nd    = in_dat[3:0];
    hdr_ok    = (len_q != 8'd0) && (len_q <= MAX_LEN) && (hdr_nd != 4'd0) &&
                ({5'd0, hdr_nd} <= {len_q, 1'b0});
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC: if (in_vld && in_dat == 8'hAA) state_nxt = H1;
      H1: begin
        if (tmo_hit)     state_nxt = SYNC;
        else if (in_vld) state_nxt = H2;
      end
      H2: begin
        if (tmo_hit)     state_nxt = SYNC;
        else if (in_vld) state_nxt = H3;
      end
      H3: begin
        if (tmo_hit)     state_nxt = SYNC;
        else if (in_vld) state_nxt = (hdr_ok && hdr_lines != 12'd0) ? LOAD : SYNC;
      end
      LOAD: begin
        if (tmo_hit)       state_nxt = SYNC;
        else if (line_end) state_nxt = HOLD;
      end
      HOLD: if (handshake) state_nxt = (remaining == 12'd1) ? SYNC : LOAD;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    line_valid = (state == HOLD);
    line_last  = (remaining == 12'd1);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      line_data  <= '0;
      line_bytes <= '0;
      n_lines    <= '0;
      n_digits   <= '0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      par_err    <= 1'b0;
      ovr_err    <= 1'b0;
      tmo_err    <= 1'b0;
      skid_full  <= 1'b0;
      skid_dat   <= '0;
      len_q      <= '0;
      lines_hi   <= '0;
      remaining  <= '0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      tmo_err    <= 1'b0;

      if (!timed || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 17'd1;

      if (state == HOLD) begin
        if (rx_valid) begin
          if (skid_full) begin
            ovr_err <= 1'b1;
          end else begin
            skid_full <= 1'b1;
            skid_dat  <= rx_data;
          end
        end
      end else if (tmo_hit) begin
        skid_full <= 1'b0;
      end else if (skid_full) begin
        skid_full <= rx_valid;
        skid_dat  <= rx_data;
      end

      if (tmo_hit) begin
        tmo_err   <= 1'b1;
        line_data <= '0;
        byte_cnt  <= '0;
      end else if (in_vld) begin
        case (state)
          H1: len_q    <= in_dat;
          H2: lines_hi <= in_dat;
          H3: begin
            if (hdr_ok) begin
              line_bytes <= len_q;
              n_lines    <= hdr_lines;
              n_digits   <= hdr_nd;
              par_err    <= 1'b0;
              ovr_err    <= 1'b0;
              remaining  <= hdr_lines;
              line_data  <= '0;
              byte_cnt   <= '0;
              if (hdr_lines == 12'd0) frame_done <= 1'b1;
            end else begin
              hdr_err <= 1'b1;
            end
          end
          LOAD: begin
            line_data <= {line_data[DW-9:0], in_dat};
            byte_cnt  <= line_end ? 8'd0 : byte_cnt + 8'd1;
          end
          default: ;
        endcase
      end

      if (handshake) begin
        remaining <= remaining - 12'd1;
        line_data <= '0;
        byte_cnt  <= '0;
        if (remaining == 12'd1) frame_done <= 1'b1;
      end

      // A bad byte in the new frame's header outranks that header's clear.
      if (rx_valid && !rx_par_ok && state != SYNC) par_err <= 1'b1;
    end
  end
endmodule

// File: doc/day3_line_framer.md
Name: day3_line_framer

Overview:
- Upstream stage of the day-3 digit-selection datapath. It consumes the byte stream from ua_rx, checks the frame header and extracts its fields.
- It assembles each input line into a right-justified 400-bit BCD word and presents it to the max-digit/summing stage over a valid/ready handshake.
- It replaces the ad-hoc HEAD/RECV logic in the top level and adds sync checking, range checking, skid buffering and timeout recovery.

Parameters:
- MAX_BYTES, 50, maximum bytes per line (2 BCD digits per byte); line_data width is 8*MAX_BYTES.
- TIMEOUT, 120000, sysclk cycles of inter-byte silence tolerated mid-frame (10 ms at 12 MHz).

Ports:
- sysclk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from ua_rx
- rx_valid  in  1  single-cycle strobe, rx_data valid
- rx_par_ok  in  1  parity status of the current byte
- line_data  out  400  current line, last byte in bits [7:0], unused upper bits zero
- line_valid  out  1  line_data holds a complete line
- line_ready  in  1  downstream accepts the line
- line_last  out  1  qualifies line_valid: this is the final line of the frame
- line_bytes  out  8  header LEN field
- n_lines  out  12  header line count
- n_digits  out  4  header digits-per-line field
- frame_done  out  1  single-cycle pulse, frame complete
- hdr_err  out  1  single-cycle pulse, header rejected
- par_err  out  1  sticky parity error flag, cleared at the next accepted header
- ovr_err  out  1  sticky overrun flag, cleared at the next accepted header
- tmo_err  out  1  single-cycle pulse, mid-frame timeout

Behaviour:
- Reset: every output is 0, state is SYNC, skid buffer is empty, all counters are 0. Reset is asynchronous and acts at any point, including mid-line.
- Header: 4 bytes, 0xAA, LEN, {LINES[11:4]}, {LINES[3:0],ND}.
- States: SYNC, H1, H2, H3, LOAD, HOLD.
- SYNC:
  - A byte equal to 0xAA moves to H1.
  - Any other byte is discarded silently.
- H1: store LEN, go to H2.
- H2: store LINES high byte, go to H3.
- H3: store LINES low nibble and ND, then validate.
  - Reject if LEN == 0, LEN > MAX_BYTES, ND == 0, or ND > 2*LEN. On reject, pulse hdr_err and return to SYNC; header outputs keep their previous values.
  - Accept otherwise: update line_bytes, n_lines and n_digits; clear par_err and ovr_err; load the remaining-lines count with LINES.
  - If LINES == 0, pulse frame_done on the following cycle and return to SYNC.
  - Otherwise clear line_data and the byte counter, then go to LOAD.
- LOAD:
  - Each byte shifts in: line_data <= {line_data[391:0], byte}.
  - On byte LEN, go to HOLD and assert line_valid on the next cycle. Latency is 1 cycle from the final rx_valid.
  - line_last = (remaining == 1).
- HOLD:
  - line_valid stays high and line_data stays stable until line_valid && line_ready.
  - On that handshake cycle: decrement remaining and clear line_data.
    - If this was the last line: pulse frame_done next cycle, go to SYNC.
    - Otherwise go to LOAD.
- Skid buffer (1 byte):
  - A byte arriving in HOLD is stored in the skid buffer and consumed as the first byte of the next line after the handshake.
  - A byte arriving while the skid buffer is full sets ovr_err and is dropped.
  - When leaving HOLD to SYNC, a buffered byte is fed to SYNC.
- Simultaneous events: rx_valid on the same cycle as the handshake goes to the skid buffer. The buffer is drained on the first cycle in LOAD, before new input; a new byte arriving that cycle waits in the buffer.
- Parity: a byte with rx_par_ok == 0 in any state other than SYNC sets par_err. The byte is still used.
- Timeout:
  - The counter runs in H1, H2, H3 and LOAD and resets on every rx_valid.
  - When it reaches TIMEOUT: pulse tmo_err, discard the partial line and skid contents, return to SYNC.
  - No timeout applies in HOLD or SYNC.
- Widths: the remaining-lines counter is 12 bits, the byte counter 8 bits, the timeout counter 17 bits.

Test Plan:
- Reset → all outputs 0. Send AA 02 00 23 then bytes 98 76, 12 34 with line_ready tied to 1:
  - line_valid pulses twice, with line_data[15:0] = 0x9876, then 0x1234.
  - line_last = 1 on the second line only.
  - n_lines = 2, n_digits = 3, line_bytes = 2, then one frame_done pulse.
- Garbage bytes 00 55 before AA 01 00 11 07 → the garbage is ignored, one line 0x07 is delivered, then frame_done.
- Bad headers → hdr_err pulse and state SYNC for each of:
  - AA 00 00 11 (LEN = 0)
  - AA 33 00 11 (LEN = 51 > MAX_BYTES)
  - AA 01 00 13 (ND = 3 > 2*LEN)
- line_ready held low while 2 bytes arrive → the first is held in the skid buffer and the second sets ovr_err. After release, the next line starts with the buffered byte.
- Header AA 02 00 12 then a single byte, then silence for TIMEOUT cycles → tmo_err pulse, return to SYNC, no line_valid. A following valid frame is processed normally.
- A byte with rx_par_ok = 0 mid-line → par_err stays set, the line is still delivered, and par_err is cleared by the next accepted header. Assert reset_n low mid-LOAD → outputs are 0 immediately, without waiting for a clock edge.
